// File: rtl/bus_rr_sched.sv
// bus_rr_sched: round-robin scheduler moving one packet per transfer from driver FIFOs to receiver FIFOs.
// Optional BUS_STATS_EN adds saturating delivered/dropped packet counters.
module bus_rr_sched #(
  parameter int DRVRS = 4,
  parameter int PCKG_SZ = 16,
  parameter int ID_W = 8,
  parameter logic [ID_W-1:0] BROAD = 8'hFF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [DRVRS-1:0]           pndng,
  input  logic [DRVRS*PCKG_SZ-1:0]   D_pop,
  output logic [DRVRS-1:0]           pop,
  output logic [DRVRS-1:0]           push,
  output logic [PCKG_SZ-1:0]         D_push,
  output logic [$clog2(DRVRS)-1:0]   grant_id,
`ifdef BUS_STATS_EN
  output logic [15:0]                pkt_cnt,
  output logic [15:0]                drop_cnt,
`endif
  output logic                       busy
);
  localparam int GW = $clog2(DRVRS);
  localparam logic [1:0] IDLE = 2'd0, POP = 2'd1, PUSH = 2'd2;
  logic [1:0] state;
  logic [GW-1:0] win;
  logic [PCKG_SZ-1:0] head;
  logic [ID_W-1:0] dest;
  logic [DRVRS-1:0] self, route;
  // Scanning from the farthest candidate down lets the nearest requester after grant_id win.
  always_comb begin
    win = grant_id;
    for (int k = DRVRS; k >= 1; k--)
      if (pndng[(int'(grant_id) + k) % DRVRS]) win = GW'((int'(grant_id) + k) % DRVRS);
  end
  assign head = D_pop[grant_id*PCKG_SZ +: PCKG_SZ];
  assign dest = head[PCKG_SZ-1 -: ID_W];
  assign self = DRVRS'(1) << grant_id;
  // Out-of-range destinations shift the bit off the top, so they drop along with self-addressed ones.
  assign route = dest == BROAD ? ~self : (DRVRS'(1) << dest) & ~self;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      pop <= '0;
      push <= '0;
      D_push <= '0;
      busy <= 1'b0;
      grant_id <= GW'(DRVRS - 1);
    end else begin
      pop <= '0;
      push <= '0;
      case (state)
        IDLE: if (|pndng) begin
          grant_id <= win;
          pop <= DRVRS'(1) << win;
          busy <= 1'b1;
          state <= POP;
        end
        POP: begin
          D_push <= head;
          push <= route;
          state <= PUSH;
        end
        default: begin
          busy <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
`ifdef BUS_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pkt_cnt <= '0;
      drop_cnt <= '0;
    end else if (state == PUSH) begin
      if (|push) pkt_cnt <= pkt_cnt == 16'hFFFF ? pkt_cnt : pkt_cnt + 16'd1;
      else drop_cnt <= drop_cnt == 16'hFFFF ? drop_cnt : drop_cnt + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_bus_rr_sched.sv
// tb_bus_rr_sched: bench FIFOs feed the scheduler; a transfer-level model predicts every output each cycle.
module tb_bus_rr_sched;
  localparam int N = 4, W = 16;
  logic clk = 1'b0, reset = 1'b0;
  logic [N-1:0] pndng = '0;
  logic [N*W-1:0] D_pop = '0;
  logic [N-1:0] pop, push;
  logic [W-1:0] D_push;
  logic [1:0] grant_id;
  logic busy;
`ifdef BUS_STATS_EN
  logic [15:0] pkt_cnt, drop_cnt;
`endif
  int errors = 0, checks = 0, cyc = 0;
  always #5 clk = ~clk;
  bus_rr_sched dut (
    .clk(clk), .reset(reset), .pndng(pndng), .D_pop(D_pop), .pop(pop), .push(push),
    .D_push(D_push), .grant_id(grant_id),
`ifdef BUS_STATS_EN
    .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt),
`endif
    .busy(busy));
  logic [W-1:0] q[N][$];
  logic [N-1:0] pend_pop = '0;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic void refresh();
    for (int i = 0; i < N; i++) begin
      pndng[i] = q[i].size() != 0;
      D_pop[i*W +: W] = q[i].size() != 0 ? q[i][0] : '0;
    end
  endfunction
  // Receivers addressed by a packet from driver w: broadcast reaches all others, a valid unicast one.
  function automatic logic [N-1:0] targets(input logic [W-1:0] d, input int w);
    logic [N-1:0] m = '0;
    for (int j = 0; j < N; j++) m[j] = j != w && (d[15:8] == 8'hFF || int'(d[15:8]) == j);
    return m;
  endfunction
  // Transfer-level model: phase counts cycles since a grant, ptr is the last granted driver.
  int m_ptr = N - 1, m_ph = 0;
  logic [N-1:0] e_pop = '0, e_push = '0;
  logic [W-1:0] e_d = '0;
  logic e_busy = 1'b0;
  logic [15:0] e_pkt = '0, e_drop = '0;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_ptr = N - 1; m_ph = 0; e_pop = '0; e_push = '0; e_d = '0; e_busy = 1'b0; e_pkt = '0; e_drop = '0;
    end else if (m_ph == 0) begin
      e_push = '0;
      e_busy = 1'b0;
      for (int k = 1; k <= N; k++)
        if (m_ph == 0 && pndng[(m_ptr + k) % N]) begin
          m_ptr = (m_ptr + k) % N;
          m_ph = 1;
        end
      if (m_ph == 1) begin
        e_pop = N'(1) << m_ptr;
        e_busy = 1'b1;
      end
    end else if (m_ph == 1) begin
      e_pop = '0;
      e_d = D_pop[m_ptr*W +: W];
      e_push = targets(e_d, m_ptr);
      m_ph = 2;
    end else begin
      if (e_push != 0) e_pkt = e_pkt == 16'hFFFF ? e_pkt : e_pkt + 16'd1;
      else e_drop = e_drop == 16'hFFFF ? e_drop : e_drop + 16'd1;
      e_push = '0;
      e_busy = 1'b0;
      m_ph = 0;
    end
  end
  always @(negedge clk) begin
    check("cycle pop/push/dpush/busy/grant", {pop, push, D_push, busy, grant_id},
          {e_pop, e_push, e_d, e_busy, 2'(m_ptr)});
`ifdef BUS_STATS_EN
    check("cycle stats", {pkt_cnt, drop_cnt}, {e_pkt, e_drop});
`endif
  end
  always @(posedge clk) begin
    pend_pop <= pop;
    cyc <= cyc + 1;
  end
  always @(negedge clk) begin
    for (int i = 0; i < N; i++)
      if (pend_pop[i] && q[i].size() != 0) void'(q[i].pop_front());
    refresh();
  end
  task automatic wait_pop();
    int c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (pop == 0 && c < 40);
    if (pop == 0) begin
      checks++;
      errors++;
      $display("FAIL wait_pop: pop stayed 0 for %0d cycles, required a grant", c);
    end
  endtask
  task automatic xfer(input string name, input int drv, input logic [W-1:0] data, input logic [N-1:0] exp_push);
    q[drv].push_back(data);
    refresh();
    wait_pop();
    check({name, " pop"}, pop, N'(1) << drv);
    @(negedge clk);
    check({name, " push"}, push, exp_push);
    check({name, " D_push"}, D_push, data);
    @(negedge clk);
    check({name, " busy fall"}, busy, 0);
  endtask
  task automatic do_reset(input int n);
    @(negedge clk);
    #2 reset = 1'b0;
    repeat (n) @(negedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
  endtask
  initial begin
    int last;
    logic [7:0] dest;
    repeat (3) @(negedge clk);
    check("reset outputs", {pop, push, busy, grant_id}, {4'b0, 4'b0, 1'b0, 2'd3});
    #2 reset = 1'b1;
    repeat (2) @(negedge clk);
    check("idle after release", {pop, push, busy, grant_id}, {4'b0, 4'b0, 1'b0, 2'd3});
    xfer("unicast", 0, 16'h02AB, 4'b0100);
    xfer("broadcast", 2, 16'hFF5A, 4'b1011);
    do_reset(2);
    for (int k = 0; k < 2; k++) begin
      q[0].push_back(16'h0100 + W'(k));
      for (int i = 1; i < N; i++) q[i].push_back(16'h0010 * W'(i) + W'(k));
    end
    refresh();
    last = 0;
    for (int g = 0; g < 5; g++) begin
      wait_pop();
      check("rr grant_id", grant_id, g % N);
      check("rr pop one-hot", pop, N'(1) << (g % N));
      if (g > 0) check("rr spacing", cyc - last, 3);
      last = cyc;
    end
    repeat (12) @(negedge clk);
    do_reset(2);
    xfer("drop self", 1, 16'h0133, 4'b0000);
    xfer("drop range", 1, 16'h0944, 4'b0000);
`ifdef BUS_STATS_EN
    check("drop_cnt", drop_cnt, 2);
    check("pkt_cnt", pkt_cnt, 0);
`endif
    q[1].push_back(16'h0377);
    refresh();
    wait_pop();
    #2 reset = 1'b0;
    #1 check("mid reset outputs", {pop, push, busy, grant_id}, {4'b0, 4'b0, 1'b0, 2'd3});
    @(negedge clk);
    #2 reset = 1'b1;
    wait_pop();
    check("post reset pop", pop, 4'b0010);
    check("post reset grant", grant_id, 1);
    repeat (3) @(negedge clk);
    for (int t = 0; t < 600; t++) begin
      @(negedge clk);
      if ($urandom_range(0, 2) == 0) begin
        int d = $urandom_range(0, N - 1);
        int s = $urandom_range(0, 5);
        dest = s < 3 ? 8'($urandom_range(0, N - 1)) : s == 3 ? 8'hFF : 8'($urandom_range(4, 255));
        if (q[d].size() < 4) begin
          q[d].push_back({dest, 8'($urandom)});
          refresh();
        end
      end
    end
    for (int t = 0; t < 200 && (pndng != 0 || busy); t++) @(negedge clk);
    if (pndng != 0 || busy) begin
      errors++;
      $display("FAIL drain: pndng=%b busy=%b after 200 cycles, required empty and idle", pndng, busy);
    end
    checks++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end
endmodule
